// File: rtl/mem_pkg.sv
// Shared types and per-element constants for the mem_bist RAM and its March C- engine.
package mem_pkg;

  typedef enum logic [2:0] {
    M0,
    M1,
    M2,
    M3,
    M4,
    M5
  } march_elem_e;

  // One state per element phase: RD issues the read, CHK compares and writes back.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_M0,
    ST_M1_RD,
    ST_M1_CHK,
    ST_M2_RD,
    ST_M2_CHK,
    ST_M3_RD,
    ST_M3_CHK,
    ST_M4_RD,
    ST_M4_CHK,
    ST_M5_RD,
    ST_M5_CHK
  } bist_state_e;

  typedef struct packed {
    logic down;
    logic rd_val;
    logic wr_val;
    logic has_write;
  } elem_cfg_t;

  function automatic logic elem_is_down(march_elem_e e);
    return (e == M3) || (e == M4);
  endfunction

  function automatic elem_cfg_t elem_cfg(march_elem_e e);
    elem_cfg_t c;
    c = '0;
    c.down = elem_is_down(e);
    case (e)
      M0:      begin c.rd_val = 1'b0; c.wr_val = 1'b0; c.has_write = 1'b1; end
      M1:      begin c.rd_val = 1'b0; c.wr_val = 1'b1; c.has_write = 1'b1; end
      M2:      begin c.rd_val = 1'b1; c.wr_val = 1'b0; c.has_write = 1'b1; end
      M3:      begin c.rd_val = 1'b0; c.wr_val = 1'b1; c.has_write = 1'b1; end
      M4:      begin c.rd_val = 1'b1; c.wr_val = 1'b0; c.has_write = 1'b1; end
      M5:      begin c.rd_val = 1'b0; c.wr_val = 1'b0; c.has_write = 1'b0; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Idle maps to M0 so the address preload for a new run is the M0 start.
  function automatic march_elem_e state_elem(bist_state_e s);
    case (s)
      ST_M1_RD, ST_M1_CHK: return M1;
      ST_M2_RD, ST_M2_CHK: return M2;
      ST_M3_RD, ST_M3_CHK: return M3;
      ST_M4_RD, ST_M4_CHK: return M4;
      ST_M5_RD, ST_M5_CHK: return M5;
      default:             return M0;
    endcase
  endfunction

endpackage

// File: rtl/mem_core.sv
// Single-port synchronous RAM: one write port, registered read-first read port.
module mem_core #(
  parameter int unsigned ADR_SIZE  = 4,
  parameter int unsigned DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADR_SIZE-1:0]  adr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic                 wr_en,
  input  logic                 rd_en,
  output logic [DATA_SIZE-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADR_SIZE;

  logic [DEPTH-1:0][DATA_SIZE-1:0] ram;

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram[adr] <= wdata;
    end
  end

  // Non-blocking read samples the pre-write word when both strobes are high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= ram[adr];
    end
  end

endmodule

// File: rtl/mem_bist.sv
// Data RAM with an integrated March C- engine: FSM, address counter, compare and fail capture.
module mem_bist
  import mem_pkg::*;
#(
  parameter int unsigned ADR_SIZE  = 4,
  parameter int unsigned DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADR_SIZE-1:0]  adress,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic                 wr_en,
  input  logic                 read_en,
  output logic [DATA_SIZE-1:0] rdata,
  input  logic                 bist_start,
  output logic                 bist_busy,
  output logic                 bist_done,
  output logic                 bist_fail,
  output logic [ADR_SIZE-1:0]  fail_adr
);

  localparam int unsigned DEPTH = 2 ** ADR_SIZE;
  localparam logic [ADR_SIZE-1:0] ADR_LAST = ADR_SIZE'(DEPTH - 1);

  bist_state_e           state;
  bist_state_e           state_nxt;
  logic [ADR_SIZE-1:0]   adr_q;
  logic [ADR_SIZE-1:0]   adr_nxt;
  elem_cfg_t             cfg;
  logic                  idle_c;
  logic                  at_last_c;
  logic                  step_c;
  logic                  chk_c;
  logic                  bist_rd_c;
  logic                  bist_wr_c;
  logic [DATA_SIZE-1:0]  exp_c;
  logic [DATA_SIZE-1:0]  bist_wdata_c;
  logic [ADR_SIZE-1:0]   core_adr_c;
  logic [DATA_SIZE-1:0]  core_wdata_c;
  logic                  core_wr_c;
  logic                  core_rd_c;

  assign cfg          = elem_cfg(state_elem(state));
  assign idle_c       = (state == ST_IDLE);
  assign at_last_c    = (adr_q == (cfg.down ? '0 : ADR_LAST));
  assign exp_c        = {DATA_SIZE{cfg.rd_val}};
  assign bist_wdata_c = {DATA_SIZE{cfg.wr_val}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      adr_q <= '0;
    end else begin
      state <= state_nxt;
      adr_q <= adr_nxt;
    end
  end

  // Next state, engine strobes and address stepping.
  always_comb begin
    state_nxt = state;
    adr_nxt   = adr_q;
    step_c    = 1'b0;
    chk_c     = 1'b0;
    bist_rd_c = 1'b0;
    bist_wr_c = 1'b0;
    case (state)
      ST_IDLE:   if (bist_start) state_nxt = ST_M0;
      ST_M0:     if (at_last_c) state_nxt = ST_M1_RD;
      ST_M1_RD:  state_nxt = ST_M1_CHK;
      ST_M1_CHK: state_nxt = at_last_c ? ST_M2_RD : ST_M1_RD;
      ST_M2_RD:  state_nxt = ST_M2_CHK;
      ST_M2_CHK: state_nxt = at_last_c ? ST_M3_RD : ST_M2_RD;
      ST_M3_RD:  state_nxt = ST_M3_CHK;
      ST_M3_CHK: state_nxt = at_last_c ? ST_M4_RD : ST_M3_RD;
      ST_M4_RD:  state_nxt = ST_M4_CHK;
      ST_M4_CHK: state_nxt = at_last_c ? ST_M5_RD : ST_M4_RD;
      ST_M5_RD:  state_nxt = ST_M5_CHK;
      ST_M5_CHK: state_nxt = at_last_c ? ST_IDLE : ST_M5_RD;
      default:   state_nxt = ST_IDLE;
    endcase

    case (state)
      ST_IDLE: adr_nxt = '0;
      ST_M0: begin
        bist_wr_c = 1'b1;
        step_c    = 1'b1;
      end
      ST_M1_RD, ST_M2_RD, ST_M3_RD, ST_M4_RD, ST_M5_RD: bist_rd_c = 1'b1;
      ST_M1_CHK, ST_M2_CHK, ST_M3_CHK, ST_M4_CHK, ST_M5_CHK: begin
        chk_c     = 1'b1;
        bist_wr_c = cfg.has_write;
        step_c    = 1'b1;
      end
      default: adr_nxt = '0;
    endcase

    // End of element reloads the start address of the next one with no gap cycle.
    if (step_c) begin
      if (at_last_c) begin
        adr_nxt = elem_is_down(state_elem(state_nxt)) ? ADR_LAST : '0;
      end else if (cfg.down) begin
        adr_nxt = adr_q - ADR_SIZE'(1);
      end else begin
        adr_nxt = adr_q + ADR_SIZE'(1);
      end
    end
  end

  // Functional port owns the array only while idle, including the start cycle.
  assign core_adr_c   = idle_c ? adress  : adr_q;
  assign core_wdata_c = idle_c ? wdata   : bist_wdata_c;
  assign core_wr_c    = idle_c ? wr_en   : bist_wr_c;
  assign core_rd_c    = idle_c ? read_en : bist_rd_c;

  mem_core #(
    .ADR_SIZE  (ADR_SIZE),
    .DATA_SIZE (DATA_SIZE)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .adr   (core_adr_c),
    .wdata (core_wdata_c),
    .wr_en (core_wr_c),
    .rd_en (core_rd_c),
    .rdata (rdata)
  );

  // Status flags: cleared by an accepted start, fail address holds the first miscompare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bist_busy <= 1'b0;
      bist_done <= 1'b0;
      bist_fail <= 1'b0;
      fail_adr  <= '0;
    end else begin
      bist_busy <= (state_nxt != ST_IDLE);
      if (idle_c && bist_start) begin
        bist_done <= 1'b0;
        bist_fail <= 1'b0;
        fail_adr  <= '0;
      end else begin
        if ((state == ST_M5_CHK) && at_last_c) begin
          bist_done <= 1'b1;
        end
        if (chk_c && (rdata != exp_c)) begin
          bist_fail <= 1'b1;
          if (!bist_fail) begin
            fail_adr <= adr_q;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bist.sv
// Bench for mem_bist: random functional traffic against an array model, March C- runs against an algorithmic fault model.
module tb_mem_bist;

  localparam int unsigned ADR_SIZE   = 4;
  localparam int unsigned DATA_SIZE  = 8;
  localparam int unsigned N          = 16;
  localparam int          RUN_CYCLES = 11 * N;
  localparam int          MAX_CYCLES = 1000;

  logic                 clk;
  logic                 rst_n;
  logic [ADR_SIZE-1:0]  adress;
  logic [DATA_SIZE-1:0] wdata;
  logic                 wr_en;
  logic                 read_en;
  logic [DATA_SIZE-1:0] rdata;
  logic                 bist_start;
  logic                 bist_busy;
  logic                 bist_done;
  logic                 bist_fail;
  logic [ADR_SIZE-1:0]  fail_adr;

  int n_checks;
  int n_fail;

  logic [DATA_SIZE-1:0] mem_ref [N];
  logic [DATA_SIZE-1:0] s0 [N];
  logic [DATA_SIZE-1:0] s1 [N];
  logic [DATA_SIZE-1:0] fin [N];
  bit                   exp_fail;
  int                   exp_adr;

  mem_bist #(
    .ADR_SIZE  (ADR_SIZE),
    .DATA_SIZE (DATA_SIZE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .adress     (adress),
    .wdata      (wdata),
    .wr_en      (wr_en),
    .read_en    (read_en),
    .rdata      (rdata),
    .bist_start (bist_start),
    .bist_busy  (bist_busy),
    .bist_done  (bist_done),
    .bist_fail  (bist_fail),
    .fail_adr   (fail_adr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // March C- on a word array where s0/s1 masks pin cells to 0/1.
  function automatic void march_model(input logic [DATA_SIZE-1:0] m0 [N], input logic [DATA_SIZE-1:0] m1 [N],
                                      output bit fail, output int fadr, output logic [DATA_SIZE-1:0] m [N]);
    bit dn [6];
    bit rv [6];
    bit wv [6];
    dn = '{0, 0, 0, 1, 1, 0};
    rv = '{0, 0, 1, 0, 1, 0};
    wv = '{0, 1, 0, 1, 0, 0};
    fail = 0;
    fadr = 0;
    for (int a = 0; a < N; a++) m[a] = (DATA_SIZE'($urandom) & ~m0[a]) | m1[a];
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < N; k++) begin
        int a;
        a = dn[e] ? (N - 1 - k) : k;
        if (e != 0 && m[a] != {DATA_SIZE{rv[e]}}) begin
          if (!fail) fadr = a;
          fail = 1;
        end
        if (e != 5) m[a] = ({DATA_SIZE{wv[e]}} & ~m0[a]) | m1[a];
      end
    end
  endfunction

  task automatic idle_inputs();
    wr_en = 1'b0;
    read_en = 1'b0;
    bist_start = 1'b0;
  endtask

  task automatic clear_faults();
    for (int a = 0; a < N; a++) begin
      s0[a] = '0;
      s1[a] = '0;
    end
  endtask

  task automatic do_write(input logic [ADR_SIZE-1:0] a, input logic [DATA_SIZE-1:0] d);
    adress = a;
    wdata = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    mem_ref[a] = d;
  endtask

  task automatic do_read(input logic [ADR_SIZE-1:0] a, output logic [DATA_SIZE-1:0] d);
    adress = a;
    read_en = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
    d = rdata;
  endtask

  // Pulses start, then counts busy cycles; optional noise on the functional port and a second start.
  task automatic run_bist(input int extra_start, input bit noise, output int cycles);
    bist_start = 1'b1;
    @(negedge clk);
    bist_start = 1'b0;
    n_checks++;
    if (bist_busy !== 1'b1 || bist_done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_accept: busy=%b done=%b, required busy=1 done=0", bist_busy, bist_done);
    end
    cycles = 0;
    while (bist_busy === 1'b1 && cycles < MAX_CYCLES) begin
      cycles++;
      bist_start = (cycles == extra_start);
      if (noise) begin
        adress = ADR_SIZE'($urandom);
        wdata = DATA_SIZE'($urandom);
        wr_en = 1'($urandom);
        read_en = 1'($urandom);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic check_run(input string name, input int cycles);
    n_checks++;
    if (cycles !== RUN_CYCLES) begin
      n_fail++;
      $display("FAIL %s_len: busy cycles=%0d, required %0d", name, cycles, RUN_CYCLES);
    end
    n_checks++;
    if (bist_done !== 1'b1 || bist_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done: done=%b busy=%b, required done=1 busy=0", name, bist_done, bist_busy);
    end
    n_checks++;
    if (bist_fail !== exp_fail) begin
      n_fail++;
      $display("FAIL %s_fail: fail=%b, required %b", name, bist_fail, exp_fail);
    end
    n_checks++;
    if (fail_adr !== ADR_SIZE'(exp_adr)) begin
      n_fail++;
      $display("FAIL %s_adr: fail_adr=%0d, required %0d", name, fail_adr, exp_adr);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (bist_busy !== 1'b0 || bist_done !== 1'b0 || bist_fail !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b done=%b fail=%b, required 0 0 0", bist_busy, bist_done, bist_fail);
    end
    n_checks++;
    if (fail_adr !== '0) begin
      n_fail++;
      $display("FAIL reset_fail_adr: %0d, required 0", fail_adr);
    end
    n_checks++;
    if (rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_rdata: %h, required 00", rdata);
    end
  endtask

  task automatic test_write_read();
    logic [DATA_SIZE-1:0] d;
    logic [ADR_SIZE-1:0]  a;
    do_write(4'd3, 8'hA5);
    do_write(4'd7, 8'h3C);
    do_read(4'd3, d);
    n_checks++;
    if (d !== 8'hA5) begin n_fail++; $display("FAIL read3: rdata=%h, required a5", d); end
    do_read(4'd7, d);
    n_checks++;
    if (d !== 8'h3C) begin n_fail++; $display("FAIL read7: rdata=%h, required 3c", d); end
    adress = 4'd3;
    @(negedge clk);
    n_checks++;
    if (rdata !== 8'h3C) begin n_fail++; $display("FAIL read_hold: rdata=%h, required 3c", rdata); end
    for (int i = 0; i < N; i++) do_write(ADR_SIZE'(i), DATA_SIZE'($urandom));
    for (int i = 0; i < 40; i++) begin
      a = ADR_SIZE'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, DATA_SIZE'($urandom));
      end else begin
        do_read(a, d);
        n_checks++;
        if (d !== mem_ref[a]) begin
          n_fail++;
          $display("FAIL rand_read: adr=%0d rdata=%h, required %h", a, d, mem_ref[a]);
        end
      end
    end
  endtask

  task automatic test_read_first();
    logic [DATA_SIZE-1:0] d;
    do_write(4'd5, 8'h11);
    adress = 4'd5;
    wdata = 8'h22;
    wr_en = 1'b1;
    read_en = 1'b1;
    @(negedge clk);
    idle_inputs();
    mem_ref[5] = 8'h22;
    n_checks++;
    if (rdata !== 8'h11) begin n_fail++; $display("FAIL read_first_old: rdata=%h, required 11", rdata); end
    do_read(4'd5, d);
    n_checks++;
    if (d !== 8'h22) begin n_fail++; $display("FAIL read_first_new: rdata=%h, required 22", d); end
  endtask

  task automatic test_bist_clean();
    int cyc;
    logic [DATA_SIZE-1:0] d;
    logic [ADR_SIZE-1:0]  a;
    clear_faults();
    march_model(s0, s1, exp_fail, exp_adr, fin);
    run_bist(0, 1'b0, cyc);
    check_run("clean", cyc);
    for (int i = 0; i < 4; i++) begin
      a = ADR_SIZE'($urandom);
      do_read(a, d);
      n_checks++;
      if (d !== fin[a]) begin
        n_fail++;
        $display("FAIL post_bist_read: adr=%0d rdata=%h, required %h", a, d, fin[a]);
      end
    end
  endtask

  task automatic test_stuck_single();
    int cyc;
    clear_faults();
    s0[9] = 8'h01;
    march_model(s0, s1, exp_fail, exp_adr, fin);
    force dut.u_core.ram[9][0] = 1'b0;
    run_bist(0, 1'b0, cyc);
    release dut.u_core.ram[9][0];
    check_run("stuck9", cyc);
  endtask

  task automatic test_stuck_two();
    int cyc;
    clear_faults();
    s1[4] = 8'h08;
    s1[12] = 8'h40;
    march_model(s0, s1, exp_fail, exp_adr, fin);
    force dut.u_core.ram[4][3] = 1'b1;
    force dut.u_core.ram[12][6] = 1'b1;
    run_bist(0, 1'b0, cyc);
    release dut.u_core.ram[4][3];
    release dut.u_core.ram[12][6];
    check_run("stuck4_12", cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    clear_faults();
    march_model(s0, s1, exp_fail, exp_adr, fin);
    run_bist(37, 1'b1, cyc);
    check_run("b2b_first", cyc);
    run_bist(150, 1'b1, cyc);
    check_run("b2b_second", cyc);
  endtask

  task automatic test_reset_midrun();
    int cyc;
    clear_faults();
    s1[3] = 8'h02;
    march_model(s0, s1, exp_fail, exp_adr, fin);
    force dut.u_core.ram[3][1] = 1'b1;
    bist_start = 1'b1;
    @(negedge clk);
    bist_start = 1'b0;
    cyc = 1;
    while (cyc < 50 && bist_busy === 1'b1) begin
      cyc++;
      @(negedge clk);
    end
    n_checks++;
    if (bist_busy !== 1'b1 || bist_fail !== exp_fail || fail_adr !== ADR_SIZE'(exp_adr)) begin
      n_fail++;
      $display("FAIL midrun_pre: busy=%b fail=%b fail_adr=%0d, required 1 %b %0d",
               bist_busy, bist_fail, fail_adr, exp_fail, exp_adr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    test_reset();
    n_checks++;
    if (bist_done !== 1'b0) begin n_fail++; $display("FAIL midrun_done: %b, required 0", bist_done); end
    release dut.u_core.ram[3][1];
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_faults();
    march_model(s0, s1, exp_fail, exp_adr, fin);
    run_bist(60, 1'b1, cyc);
    check_run("after_reset", cyc);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    adress = '0;
    wdata = '0;
    idle_inputs();
    clear_faults();
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_write_read();
    test_read_first();
    test_bist_clean();
    test_stuck_single();
    test_stuck_two();
    test_back_to_back();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
